// File: rtl/ddr_burst_sequencer.sv
// Turns accepted RD/RDA/WR/WRA commands into CL/CWL-delayed data-bus bursts with wrapped columns.
// Optional burst chop (bc_n input, 4-beat bursts) is enabled by defining BURST_CHOP_EN.
module ddr_burst_sequencer #(
  parameter int BGWIDTH  = 2,
  parameter int BAWIDTH  = 2,
  parameter int COLWIDTH = 10,
  parameter int BL       = 8,
  parameter int CL       = 17,
  parameter int CWL      = 12
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0] bg,
  input  logic [BAWIDTH-1:0]                     ba,
  input  logic [COLWIDTH-1:0]                    col,
`ifdef BURST_CHOP_EN
  input  logic                                   bc_n,
`endif
  input  logic                                   RD,
  input  logic                                   RDA,
  input  logic                                   WR,
  input  logic                                   WRA,
  output logic                                   rd_en,
  output logic                                   wr_en,
  output logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0] burst_bg,
  output logic [BAWIDTH-1:0]                     burst_ba,
  output logic [COLWIDTH-1:0]                    burst_col,
  output logic                                   last_beat,
  output logic                                   ap_done,
  output logic                                   cmd_err,
  output logic                                   bus_err
);
  localparam int BGW   = (BGWIDTH > 0) ? BGWIDTH : 1;
  localparam int LOGBL = $clog2(BL);

  typedef struct packed {
    logic [BGW-1:0]      bg;
    logic [BAWIDTH-1:0]  ba;
    logic [COLWIDTH-1:0] col;
    logic                ap;
    logic                chop;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  // Stage p0: command decode
  logic [2:0] n_cmd;
  logic       cmd_multi, rd_acc, wr_acc, chop_in;
  cmd_t       cmd_p0;

  always_comb begin
    n_cmd     = 3'(RD) + 3'(RDA) + 3'(WR) + 3'(WRA);
    cmd_multi = n_cmd > 3'd1;
    rd_acc    = (RD | RDA) & ~cmd_multi;
    wr_acc    = (WR | WRA) & ~cmd_multi;
`ifdef BURST_CHOP_EN
    chop_in   = ~bc_n && (BL == 8);
`else
    chop_in   = 1'b0;
`endif
    cmd_p0.bg   = (BGWIDTH > 0) ? bg : '0;
    cmd_p0.ba   = ba;
    cmd_p0.col  = col;
    cmd_p0.ap   = RDA | WRA;
    cmd_p0.chop = chop_in;
  end

  // Stage p1: latency delay lines (valid bits reset, payload free-running)
  logic [CL-2:0]  rd_vld_p1;
  logic [CWL-2:0] wr_vld_p1;
  cmd_t           rd_line_p1 [CL-1];
  cmd_t           wr_line_p1 [CWL-1];
  logic           cmd_err_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p1  <= '0;
      wr_vld_p1  <= '0;
      cmd_err_p1 <= 1'b0;
    end else begin
      rd_vld_p1[0] <= rd_acc;
      for (int i = 1; i < CL - 1; i++) rd_vld_p1[i] <= rd_vld_p1[i-1];
      wr_vld_p1[0] <= wr_acc;
      for (int i = 1; i < CWL - 1; i++) wr_vld_p1[i] <= wr_vld_p1[i-1];
      cmd_err_p1 <= cmd_multi;
    end
  end

  always_ff @(posedge clk) begin
    rd_line_p1[0] <= cmd_p0;
    for (int i = 1; i < CL - 1; i++) rd_line_p1[i] <= rd_line_p1[i-1];
    wr_line_p1[0] <= cmd_p0;
    for (int i = 1; i < CWL - 1; i++) wr_line_p1[i] <= wr_line_p1[i-1];
  end

  // Stage p2: burst engine
  logic             start_rd, start_wr, busy, at_last, take, bus_err_nx, bus_err_p2;
  logic [LOGBL-1:0] cnt_p2, cnt_nx, last_idx;
  state_t           state_p2, state_nx;
  cmd_t             cur_p2, cur_nx;

  always_comb begin
    start_rd   = rd_vld_p1[CL-2];
    start_wr   = wr_vld_p1[CWL-2];
    busy       = state_p2 != IDLE;
    last_idx   = cur_p2.chop ? LOGBL'(3) : LOGBL'(BL - 1);
    at_last    = busy && (cnt_p2 == last_idx);
    take       = (start_rd | start_wr) && (!busy || at_last);
    // Read wins a same-edge tie; any start landing mid-burst is lost
    bus_err_nx = (start_rd & start_wr) | ((start_rd | start_wr) & busy & ~at_last);
    state_nx   = state_p2;
    cnt_nx     = cnt_p2 + 1'b1;
    cur_nx     = cur_p2;
    if (take) begin
      state_nx = start_rd ? READ : WRITE;
      cnt_nx   = '0;
      cur_nx   = start_rd ? rd_line_p1[CL-2] : wr_line_p1[CWL-2];
    end else if (at_last || !busy) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p2   <= IDLE;
      cnt_p2     <= '0;
      bus_err_p2 <= 1'b0;
    end else begin
      state_p2   <= state_nx;
      cnt_p2     <= cnt_nx;
      bus_err_p2 <= bus_err_nx;
    end
  end

  always_ff @(posedge clk) cur_p2 <= cur_nx;

  // Stage p3: registered outputs; column wraps inside the BL- (or 4-) aligned block
  logic [LOGBL-1:0]    wrap_mask, low_sum;
  logic [COLWIDTH-1:0] col_beat;

  always_comb begin
    wrap_mask = cur_p2.chop ? LOGBL'(3) : '1;
    low_sum   = cur_p2.col[LOGBL-1:0] + cnt_p2;
    col_beat  = {cur_p2.col[COLWIDTH-1:LOGBL],
                 (cur_p2.col[LOGBL-1:0] & ~wrap_mask) | (low_sum & wrap_mask)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      burst_bg  <= '0;
      burst_ba  <= '0;
      burst_col <= '0;
      last_beat <= 1'b0;
      ap_done   <= 1'b0;
      cmd_err   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      rd_en     <= state_p2 == READ;
      wr_en     <= state_p2 == WRITE;
      last_beat <= at_last;
      ap_done   <= at_last & cur_p2.ap;
      cmd_err   <= cmd_err_p1;
      bus_err   <= bus_err_p2;
      if (busy) begin
        burst_bg  <= cur_p2.bg;
        burst_ba  <= cur_p2.ba;
        burst_col <= col_beat;
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_sequencer.sv
// Randomized and directed bench for ddr_burst_sequencer against a cycle-timeline reference model.
module tb_ddr_burst_sequencer;
  localparam int BGWIDTH  = 2;
  localparam int BAWIDTH  = 2;
  localparam int COLWIDTH = 10;
  localparam int BL       = 8;
  localparam int CL       = 17;
  localparam int CWL      = 12;
  localparam int MAXC     = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] bg, ba;
  logic [9:0] col;
  logic       bc_n;
  logic       RD, RDA, WR, WRA;
  logic       rd_en, wr_en, last_beat, ap_done, cmd_err, bus_err;
  logic [1:0] burst_bg, burst_ba;
  logic [9:0] burst_col;

  always #5 clk = ~clk;

  ddr_burst_sequencer #(
    .BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .COLWIDTH(COLWIDTH),
    .BL(BL), .CL(CL), .CWL(CWL)
  ) dut (
    .clk(clk), .reset(reset), .bg(bg), .ba(ba), .col(col),
`ifdef BURST_CHOP_EN
    .bc_n(bc_n),
`endif
    .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA),
    .rd_en(rd_en), .wr_en(wr_en), .burst_bg(burst_bg), .burst_ba(burst_ba),
    .burst_col(burst_col), .last_beat(last_beat), .ap_done(ap_done),
    .cmd_err(cmd_err), .bus_err(bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus per edge: cmd bits {RD,RDA,WR,WRA}
  logic [3:0] st_cmd [MAXC];
  logic [1:0] st_bg  [MAXC];
  logic [1:0] st_ba  [MAXC];
  logic [9:0] st_col [MAXC];

  bit         e_rd [MAXC], e_wr [MAXC], e_last [MAXC], e_ap [MAXC], e_bus [MAXC], e_cmd [MAXC];
  logic [9:0] e_col [MAXC];
  logic [1:0] e_bg [MAXC], e_ba [MAXC];

  logic       o_rd [MAXC], o_last [MAXC], o_ap [MAXC], o_bus [MAXC], o_cmd [MAXC];
  logic [9:0] o_col [MAXC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_cmd[i] = 4'b0000;
      st_bg[i]  = 2'd0;
      st_ba[i]  = 2'd0;
      st_col[i] = 10'd0;
    end
  endtask

  // Timeline model: each legal command wants the bus from issue+latency for BL beats;
  // requests are granted in time order (read first on a tie) if the bus is free by then.
  task automatic build_model(input int n);
    int busy_until, kr, kw, k, cv, base;
    bit sr, sw;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_last[i] = 0; e_ap[i] = 0; e_bus[i] = 0; e_cmd[i] = 0;
      e_col[i] = '0; e_bg[i] = '0; e_ba[i] = '0;
    end
    busy_until = -1;
    for (int s = 0; s < n; s++) begin
      if (s >= 1 && $countones(st_cmd[s-1]) > 1) e_cmd[s] = 1;
      kr = s - CL;
      kw = s - CWL;
      sr = (kr >= 0) && ($countones(st_cmd[kr]) == 1) && (st_cmd[kr][3] || st_cmd[kr][2]);
      sw = (kw >= 0) && ($countones(st_cmd[kw]) == 1) && (st_cmd[kw][1] || st_cmd[kw][0]);
      if (sr && sw) e_bus[s] = 1;
      if (sr || sw) begin
        if (s <= busy_until) e_bus[s] = 1;
        else begin
          k    = sr ? kr : kw;
          cv   = int'(st_col[k]);
          base = cv - (cv % BL);
          for (int b = 0; b < BL; b++) begin
            e_rd[s+b]  = sr;
            e_wr[s+b]  = !sr;
            e_col[s+b] = 10'(base + ((cv % BL) + b) % BL);
            e_bg[s+b]  = st_bg[k];
            e_ba[s+b]  = st_ba[k];
          end
          e_last[s+BL-1] = 1;
          e_ap[s+BL-1]   = sr ? st_cmd[k][2] : st_cmd[k][0];
          busy_until     = s + BL - 1;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    {RD, RDA, WR, WRA} = 4'b0000;
    bg = 2'd0; ba = 2'd0; col = 10'd0; bc_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("reset_outputs",
        {12'd0, rd_en, wr_en, last_beat, ap_done, cmd_err, bus_err, burst_bg, burst_ba, burst_col}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_phase(input int n, input string name);
    build_model(n);
    do_reset();
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      {RD, RDA, WR, WRA} = st_cmd[t];
      bg = st_bg[t]; ba = st_ba[t]; col = st_col[t];
      @(posedge clk);
      #1;
      o_rd[t] = rd_en; o_last[t] = last_beat; o_ap[t] = ap_done;
      o_bus[t] = bus_err; o_cmd[t] = cmd_err; o_col[t] = burst_col;
      chk($sformatf("%s rd_en@%0d", name, t), 32'(rd_en), 32'(e_rd[t]));
      chk($sformatf("%s wr_en@%0d", name, t), 32'(wr_en), 32'(e_wr[t]));
      chk($sformatf("%s last_beat@%0d", name, t), 32'(last_beat), 32'(e_last[t]));
      chk($sformatf("%s ap_done@%0d", name, t), 32'(ap_done), 32'(e_ap[t]));
      chk($sformatf("%s bus_err@%0d", name, t), 32'(bus_err), 32'(e_bus[t]));
      chk($sformatf("%s cmd_err@%0d", name, t), 32'(cmd_err), 32'(e_cmd[t]));
      if (e_rd[t] || e_wr[t]) begin
        chk($sformatf("%s burst_col@%0d", name, t), 32'(burst_col), 32'(e_col[t]));
        chk($sformatf("%s burst_bg@%0d", name, t), 32'(burst_bg), 32'(e_bg[t]));
        chk($sformatf("%s burst_ba@%0d", name, t), 32'(burst_ba), 32'(e_ba[t]));
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic random_stim(input int n);
    logic [3:0] bad [7];
    int r;
    bad[0] = 4'b0011; bad[1] = 4'b0101; bad[2] = 4'b0110; bad[3] = 4'b1001;
    bad[4] = 4'b1010; bad[5] = 4'b1100; bad[6] = 4'b1111;
    clear_stim();
    for (int t = 0; t < n - 40; t++) begin
      r = int'($urandom_range(0, 99));
      st_bg[t]  = 2'($urandom);
      st_ba[t]  = 2'($urandom);
      st_col[t] = 10'($urandom);
      if (r < 6)       st_cmd[t] = 4'b1000;
      else if (r < 10) st_cmd[t] = 4'b0100;
      else if (r < 15) st_cmd[t] = 4'b0010;
      else if (r < 19) st_cmd[t] = 4'b0001;
      else if (r < 21) st_cmd[t] = bad[$urandom_range(0, 6)];
      else             st_cmd[t] = 4'b0000;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    clear_stim();
    st_cmd[0] = 4'b1000; st_bg[0] = 2'd1; st_ba[0] = 2'd1; st_col[0] = 10'h010;
    run_phase(60, "rd_single");
    chk("rd_single first beat col", 32'(o_col[17]), 32'h010);
    chk("rd_single col beat3", 32'(o_col[20]), 32'h013);
    chk("rd_single last_beat@24", 32'(o_last[24]), 32'd1);
    chk("rd_single rd_en@25", 32'(o_rd[25]), 32'd0);

    clear_stim();
    st_cmd[0] = 4'b0001; st_bg[0] = 2'd2; st_ba[0] = 2'd3; st_col[0] = 10'h00D;
    run_phase(60, "wra_wrap");
    chk("wra_wrap col@15", 32'(o_col[15]), 32'h008);
    chk("wra_wrap col@19", 32'(o_col[19]), 32'h00C);
    chk("wra_wrap ap_done@19", 32'(o_ap[19]), 32'd1);

    clear_stim();
    st_cmd[0] = 4'b1000; st_cmd[8] = 4'b1000; st_col[8] = 10'h3F5;
    run_phase(60, "rd_seamless");
    chk("rd_seamless rd_en@25", 32'(o_rd[25]), 32'd1);
    chk("rd_seamless last_beat@32", 32'(o_last[32]), 32'd1);

    clear_stim();
    st_cmd[0] = 4'b1000; st_cmd[4] = 4'b1000;
    run_phase(60, "rd_collide");
    chk("rd_collide bus_err@21", 32'(o_bus[21]), 32'd1);
    chk("rd_collide rd_en@25", 32'(o_rd[25]), 32'd0);

    clear_stim();
    st_cmd[0] = 4'b1000; st_cmd[5] = 4'b0010;
    run_phase(60, "rw_tie");
    chk("rw_tie bus_err@17", 32'(o_bus[17]), 32'd1);
    chk("rw_tie rd_en@17", 32'(o_rd[17]), 32'd1);

    clear_stim();
    st_cmd[0] = 4'b1010;
    run_phase(60, "cmd_illegal");
    chk("cmd_illegal cmd_err@1", 32'(o_cmd[1]), 32'd1);
    chk("cmd_illegal cmd_err@2", 32'(o_cmd[2]), 32'd0);

    for (int p = 0; p < 4; p++) begin
      random_stim(300);
      run_phase(300, $sformatf("rand%0d", p));
    end

    // Reset asserted in the middle of a read burst
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      if (t == 0) begin
        RD = 1'b1; col = 10'h040; bg = 2'd3; ba = 2'd2;
      end else idle_inputs();
      @(posedge clk);
      #1;
    end
    chk("midburst rd_en@20", 32'(rd_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midburst async reset outputs",
        {12'd0, rd_en, wr_en, last_beat, ap_done, cmd_err, bus_err, burst_bg, burst_ba, burst_col}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset enables@%0d", t), {30'd0, rd_en, wr_en}, 32'd0);
      chk($sformatf("post_reset last_beat@%0d", t), 32'(last_beat), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_burst_sequencer.md
Name: ddr_burst_sequencer

Overview:
- Sits downstream of the per-bank timing FSM, alongside it on the same decoded command stream (bg, ba, RD/RDA/WR/WRA).
- Converts accepted column commands into cycle-accurate data-bus bursts.
  - Delays reads by CL and writes by CWL.
  - Counts BL beats and generates wrapped column addresses.
  - Flags the auto-precharge point for the addressed bank.
- Drives the emulated DQ datapath enables (memory array read/write ports).

Parameters:
BGWIDTH, 2, bank-group address width (0 allowed for DDR3; bg ports then 1 bit, ignored)
BAWIDTH, 2, bank address width
COLWIDTH, 10, column address width
BL, 8, burst length in beats (power of 2, 4 or 8), one beat per clk
CL, 17, read latency in clk cycles (>=2)
CWL, 12, write latency in clk cycles (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
bg  in  BGWIDTH  bank group of command
ba  in  BAWIDTH  bank of command
col  in  COLWIDTH  start column of command
RD  in  1  read command
RDA  in  1  read with auto-precharge
WR  in  1  write command
WRA  in  1  write with auto-precharge
rd_en  out  1  read beat active this cycle
wr_en  out  1  write beat active this cycle
burst_bg  out  BGWIDTH  bank group of active burst
burst_ba  out  BAWIDTH  bank of active burst
burst_col  out  COLWIDTH  column of current beat
last_beat  out  1  final beat of burst
ap_done  out  1  one-cycle pulse on last beat of RDA/WRA burst
cmd_err  out  1  one-cycle pulse: illegal command combination
bus_err  out  1  one-cycle pulse: burst dropped due to bus collision

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset clears both delay lines and the burst engine immediately, including mid-burst.
- Command sampling:
  - Exactly one of RD/RDA/WR/WRA high at a rising edge -> command accepted.
  - More than one high -> cmd_err =1 next cycle; the command is discarded.
  - None high -> no action.
- Delay lines:
  - Separate read line (CL-1 stages) and write line (CWL-1 stages).
  - Each stage holds {valid, bg, ba, col, ap}. Shift every cycle.
  - Back-to-back commands are all retained; there is no queue-full condition.
- Latency: command accepted at edge k -> first beat outputs valid after edge k+L (L=CL for reads, CWL for writes).
  - Enable stays high for edges k+L .. k+L+BL-1.
- Burst engine states:
  - IDLE: start event -> READ or WRITE; beat counter = 0.
  - READ / WRITE: counter increments each cycle. At counter = BL-1, last_beat=1; next state is IDLE, or a new burst if one starts that edge (seamless back-to-back, no gap).
- Column wrap:
  - burst_col[COLWIDTH-1:log2(BL)] = col upper bits, constant for the burst.
  - Low bits = (col low bits + beat) mod BL (sequential wrap within the BL-aligned block).
- Collisions:
  - Start event while the engine is mid-burst (not on last beat) -> new burst dropped, current burst continues, bus_err pulses.
  - Read and write start on the same edge -> read wins, write dropped, bus_err pulses.
- ap_done: asserted with last_beat when the burst came from RDA/WRA. burst_bg/burst_ba identify the bank.
- burst_bg/ba/col hold their last values in IDLE; they are don't-care for checking.

Optional Feature:
BURST_CHOP_EN
- Defined: adds input bc_n (1 bit), sampled with the command and carried in the delay lines.
  - bc_n=0 -> 4-beat burst; last_beat/ap_done on beat 3.
  - Column wraps mod 4 within a 4-aligned block.
  - Ignored when BL=4.
- Undefined: no bc_n port; every burst is BL beats.

Test Plan:
- reset released; RD bg=1 ba=1 col=0x010 at edge 0 -> rd_en high at edges 17..24; burst_col 0x010..0x017; last_beat at edge 24; ap_done stays 0.
- WRA bg=2 ba=3 col=0x00D at edge 0 -> wr_en at edges 12..19; burst_col sequence 0x00D,0x00E,0x00F,0x008,0x009,0x00A,0x00B,0x00C; ap_done=1 with last_beat at edge 19 with burst_bg=2, burst_ba=3.
- RD at edges 0 and 8 -> continuous rd_en edges 17..32, no gap; two last_beat pulses at 24 and 32; no bus_err.
- RD at edge 0, RD at edge 4 -> second burst dropped; bus_err=1 at edge 21; rd_en high only 17..24.
- WR at edge 5, RD at edge 0 (both start at edge 17) -> read burst runs, write dropped, bus_err at edge 17.
- RD and WR high at edge 0 -> cmd_err=1 at edge 1, no enables ever. Separately, reset asserted at edge 20 during a read burst -> all outputs 0 immediately; no beats after release.
